button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter NUM_BTN, default 4: number of button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000: consecutive differing samples needed to accept a new level.
REQ-003 SHALL have parameter STRETCH_CYCLES, default 100: output high time in stretch mode.
REQ-004 SHALL have port sysclk, input, 1: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port btn_raw, input, NUM_BTN: button register bits, unsynchronised.
REQ-007 SHALL have port btn_mode, input, 2*NUM_BTN: mode per button, field i = bits [2i+1:2i].
REQ-008 SHALL have port btn_db, output, NUM_BTN: debounced level per button.
REQ-009 SHALL have port btn_out, output, NUM_BTN: conditioned button, consumed by the DUT wrapper (bit 0 drives DUT rst).
REQ-010 SHALL have port press_cnt, output, 16: total accepted press events, for the status register.

Function
REQ-011 SHALL pass btn_raw through a 2-flop synchroniser before debounce; this latency is 2 cycles.
REQ-012 Each channel SHALL keep a debounce counter that increments on every edge where the synchronised input differs from btn_db[i], and clears on any edge where they match.
REQ-013 btn_db[i] SHALL take the synchronised value on the DEBOUNCE_CYCLES-th consecutive differing edge; the counter SHALL clear on that same edge.
REQ-014 A press event SHALL be the edge at which btn_db[i] goes 0->1; a release event SHALL be the edge at which it goes 1->0.
REQ-015 Mode 00 (level): btn_out[i] SHALL equal btn_db[i].
REQ-016 Mode 01 (pulse): btn_out[i] SHALL be high for exactly one cycle, starting at the press-event edge.
REQ-017 Mode 10 (toggle): btn_out[i] SHALL invert at each press-event edge; release SHALL have no effect.
REQ-018 Mode 11 (stretch): btn_out[i] SHALL go high at the press-event edge and stay high for STRETCH_CYCLES cycles; a press during stretch SHALL reload the full count.
REQ-019 btn_mode SHALL be registered per channel; on the edge after a channel's mode field changes, that channel's btn_out, toggle state and stretch counter SHALL clear to 0, and btn_db SHALL be unaffected.
REQ-020 press_cnt SHALL add the number of press events occurring in each cycle (0..NUM_BTN), modulo 2^16, with silent wrap.
REQ-021 press_cnt SHALL count presses in every mode, including level.
REQ-022 All outputs SHALL be registered except btn_out in mode 00, which is btn_db directly.

Reset
REQ-023 On rst high, all synchroniser flops, debounce counters, btn_db, the mode registers, toggle state, stretch counters, btn_out and press_cnt SHALL go to 0 immediately, without waiting for a clock edge.
REQ-024 Reset asserted mid-debounce or mid-stretch SHALL abort the operation; after release, no press event SHALL be generated until a new full debounce completes.
REQ-025 A button held high through reset release SHALL produce one press event DEBOUNCE_CYCLES+2 edges after release.

Structure
REQ-026 Package button_pkg SHALL hold the mode encodings (MODE_LEVEL=00, MODE_PULSE=01, MODE_TOGGLE=10, MODE_STRETCH=11) and the default parameter constants.
REQ-027 Per-button logic (synchroniser, debounce, mode engine) SHALL be sub-module btn_channel, generated NUM_BTN times.
REQ-028 The press_cnt adder (popcount of press events) SHALL live in the top level.

Verification (DEBOUNCE_CYCLES=4, STRETCH_CYCLES=8)
REQ-029 Mode 00, btn_raw[0] pattern 1,0,1,0 then held 1 -> btn_db[0] and btn_out[0] rise exactly 2+4 edges after the last 0->1 transition, never earlier; press_cnt 0->1.
REQ-030 Mode 01, btn_raw[1] held 1 for 30 cycles then 0 -> btn_out[1] high exactly 1 cycle; press_cnt +1; release produces no pulse.
REQ-031 Mode 10, two clean presses on btn_raw[2] separated by a 10-cycle release -> btn_out[2] goes 0->1 at press 1 and 1->0 at press 2; press_cnt +2.
REQ-032 Mode 11, press on btn_raw[3], second press debounced 5 cycles later -> btn_out[3] high continuously for 5+8=13 cycles.
REQ-033 All four pressed in the same cycle in mode 01 -> all four btn_out pulse on the same edge and press_cnt +4 in one cycle; 16384 such quad presses from 0 -> press_cnt 0x0000.
REQ-034 Mode 11 press, mode field changed to 00 after 3 stretch cycles with button still held -> btn_out[3] cleared on the next edge, then follows btn_db (1); a separate rst pulse mid-stretch -> all outputs 0 at once.

Source files
------------

// File: rtl/button_pkg.sv
// Shared mode encodings and default sizing for the button conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    MODE_LEVEL   = 2'b00,
    MODE_PULSE   = 2'b01,
    MODE_TOGGLE  = 2'b10,
    MODE_STRETCH = 2'b11
  } btn_mode_e;

  localparam int DEF_NUM_BTN         = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 1000;
  localparam int DEF_STRETCH_CYCLES  = 100;
  localparam int PRESS_CNT_W         = 16;

endpackage

// File: rtl/btn_channel.sv
// One button lane: 2-flop synchroniser, debounce filter and per-mode output engine.
module btn_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int STRETCH_CYCLES  = DEF_STRETCH_CYCLES
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_raw,
  input  logic [1:0] i_mode,
  output logic       o_db,
  output logic       o_out,
  output logic       o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(STRETCH_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_db;
  btn_mode_e     r_mode;
  logic          r_lvl;
  logic          r_out;
  logic          r_tog;
  logic [SW-1:0] r_str;

  logic w_differ;
  logic w_accept;
  logic w_press;
  logic w_mode_chg;

  assign w_differ   = (r_sync2 != r_db);
  assign w_accept   = w_differ && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign w_press    = w_accept && r_sync2;
  assign w_mode_chg = (i_mode != r_mode);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_db    <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (w_accept) begin
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else if (w_differ) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // A mode change wins over a coincident press: the lane restarts from a clean state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mode <= MODE_LEVEL;
      r_lvl  <= 1'b0;
      r_out  <= 1'b0;
      r_tog  <= 1'b0;
      r_str  <= '0;
    end else begin
      r_mode <= btn_mode_e'(i_mode);
      r_lvl  <= !w_mode_chg && (i_mode == MODE_LEVEL);
      if (w_mode_chg) begin
        r_out <= 1'b0;
        r_tog <= 1'b0;
        r_str <= '0;
      end else begin
        case (r_mode)
          MODE_LEVEL: begin
            r_out <= 1'b0;
          end
          MODE_PULSE: begin
            r_out <= w_press;
          end
          MODE_TOGGLE: begin
            r_tog <= r_tog ^ w_press;
            r_out <= r_tog ^ w_press;
          end
          MODE_STRETCH: begin
            if (w_press) begin
              r_str <= SW'(STRETCH_CYCLES - 1);
              r_out <= 1'b1;
            end else if (r_str != '0) begin
              r_str <= r_str - 1'b1;
            end else begin
              r_out <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  // Level mode bypasses the engine register so the output is the debounced flop itself.
  assign o_out   = r_lvl ? r_db : r_out;
  assign o_db    = r_db;
  assign o_press = w_press;

endmodule

// File: rtl/button_conditioner.sv
// Conditions NUM_BTN raw button bits and counts accepted press events.
module button_conditioner
  import button_pkg::*;
#(
  parameter int NUM_BTN         = DEF_NUM_BTN,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int STRETCH_CYCLES  = DEF_STRETCH_CYCLES
) (
  input  logic                   sysclk,
  input  logic                   rst,
  input  logic [NUM_BTN-1:0]     btn_raw,
  input  logic [2*NUM_BTN-1:0]   btn_mode,
  output logic [NUM_BTN-1:0]     btn_db,
  output logic [NUM_BTN-1:0]     btn_out,
  output logic [PRESS_CNT_W-1:0] press_cnt
);

  logic [NUM_BTN-1:0]     w_press;
  logic [PRESS_CNT_W-1:0] w_press_sum;
  logic [PRESS_CNT_W-1:0] r_press_cnt;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .STRETCH_CYCLES  (STRETCH_CYCLES)
    ) u_chan (
      .i_clk   (sysclk),
      .i_rst   (rst),
      .i_raw   (btn_raw[g]),
      .i_mode  (btn_mode[2*g+1:2*g]),
      .o_db    (btn_db[g]),
      .o_out   (btn_out[g]),
      .o_press (w_press[g])
    );
  end

  always_comb begin
    w_press_sum = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      w_press_sum = w_press_sum + {{(PRESS_CNT_W-1){1'b0}}, w_press[i]};
    end
  end

  // Wraps silently at 2^16.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_press_cnt <= '0;
    end else begin
      r_press_cnt <= r_press_cnt + w_press_sum;
    end
  end

  assign press_cnt = r_press_cnt;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed and randomized checks of button_conditioner against a cycle-level behavioural model.
module tb_button_conditioner;

  localparam int DB = 4;
  localparam int SC = 8;

  logic        sysclk = 1'b0;
  logic        rst    = 1'b0;
  logic [3:0]  btn_raw;
  logic [7:0]  btn_mode;
  logic [3:0]  btn_db;
  logic [3:0]  btn_out;
  logic [15:0] press_cnt;

  logic [3:0]  w_raw;
  logic [3:0]  w_db;
  logic [3:0]  w_out;
  logic [15:0] w_cnt;

  always #5 sysclk = ~sysclk;

  button_conditioner #(.NUM_BTN(4), .DEBOUNCE_CYCLES(DB), .STRETCH_CYCLES(SC)) u_dut (
    .sysclk    (sysclk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .btn_mode  (btn_mode),
    .btn_db    (btn_db),
    .btn_out   (btn_out),
    .press_cnt (press_cnt)
  );

  // Fast-debounce instance used only to reach the 16-bit counter wrap in reasonable time.
  button_conditioner #(.NUM_BTN(4), .DEBOUNCE_CYCLES(1), .STRETCH_CYCLES(1)) u_wrap (
    .sysclk    (sysclk),
    .rst       (rst),
    .btn_raw   (w_raw),
    .btn_mode  (8'h55),
    .btn_db    (w_db),
    .btn_out   (w_out),
    .press_cnt (w_cnt)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: raw history delayed two edges, streak of disagreeing samples,
  // per-lane mode behaviour expressed as press parity / stretch expiry time.
  logic [3:0]  hist[$];
  logic [3:0]  m_db;
  logic [3:0]  m_out;
  logic [15:0] m_cnt;
  int          m_streak[4];
  logic [1:0]  m_pm[4];
  logic        m_tog[4];
  int          m_expire[4];
  int          cyc;
  logic [7:0]  cur_mode;

  task automatic model_reset();
    hist.delete();
    hist.push_back(4'b0);
    hist.push_back(4'b0);
    m_db  = '0;
    m_out = '0;
    m_cnt = '0;
    for (int i = 0; i < 4; i++) begin
      m_streak[i] = 0;
      m_pm[i]     = 2'b00;
      m_tog[i]    = 1'b0;
      m_expire[i] = 0;
    end
  endtask

  task automatic model_edge(input logic [3:0] raw, input logic [7:0] mode);
    logic [3:0] v;
    logic [3:0] p;
    logic [1:0] m;
    int np;
    cyc++;
    v = hist.pop_front();
    hist.push_back(raw);
    p  = '0;
    np = 0;
    for (int i = 0; i < 4; i++) begin
      if (v[i] != m_db[i]) begin
        m_streak[i]++;
        if (m_streak[i] == DB) begin
          m_db[i]     = v[i];
          m_streak[i] = 0;
          p[i]        = v[i];
        end
      end else begin
        m_streak[i] = 0;
      end
      if (p[i]) np++;
      m = mode[2*i +: 2];
      if (m != m_pm[i]) begin
        m_pm[i]     = m;
        m_tog[i]    = 1'b0;
        m_expire[i] = 0;
        m_out[i]    = 1'b0;
      end else begin
        case (m)
          2'b00: m_out[i] = m_db[i];
          2'b01: m_out[i] = p[i];
          2'b10: begin
            if (p[i]) m_tog[i] = !m_tog[i];
            m_out[i] = m_tog[i];
          end
          default: begin
            if (p[i]) m_expire[i] = cyc + SC;
            m_out[i] = (cyc < m_expire[i]);
          end
        endcase
      end
    end
    m_cnt = m_cnt + 16'(np);
  endtask

  task automatic step(input logic [3:0] raw);
    btn_raw  = raw;
    btn_mode = cur_mode;
    @(posedge sysclk);
    model_edge(raw, cur_mode);
    @(negedge sysclk);
    check("btn_db", 16'(btn_db), 16'(m_db));
    check("btn_out", 16'(btn_out), 16'(m_out));
    check("press_cnt", press_cnt, m_cnt);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_db"}, 16'(btn_db), 16'h0);
    check({tag, "_out"}, 16'(btn_out), 16'h0);
    check({tag, "_cnt"}, press_cnt, 16'h0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hi;
    int rises;
    int quad;
    int maxd;
    logic prev3;
    logic [15:0] prev_cnt;
    logic [3:0] rr;

    btn_raw  = '0;
    btn_mode = '0;
    w_raw    = '0;
    cur_mode = '0;
    cyc      = 0;
    model_reset();

    // Reset state, visible before any clock edge.
    #1 rst = 1'b1;
    #1;
    check_zero("reset");
    check("wrap_reset_cnt", w_cnt, 16'h0);
    @(negedge sysclk);
    rst = 1'b0;
    model_reset();

    // Lane modes: 3 stretch, 2 toggle, 1 pulse, 0 level.
    cur_mode = 8'hE4;
    for (int i = 0; i < 3; i++) step(4'b0000);

    // Level: bouncing input, then held; latency from the final 0->1.
    step(4'b0001); step(4'b0000); step(4'b0001); step(4'b0000);
    n = 0;
    do begin
      step(4'b0001);
      n++;
    end while (!btn_db[0] && n < 20);
    check("level_latency", 16'(n), 16'd6);
    check("level_out", 16'(btn_out[0]), 16'h1);
    check("level_cnt", press_cnt, 16'd1);
    for (int i = 0; i < 8; i++) step(4'b0000);

    // Pulse: long hold gives one single-cycle pulse, release gives none.
    hi = 0;
    for (int i = 0; i < 42; i++) begin
      step(i < 30 ? 4'b0010 : 4'b0000);
      if (btn_out[1]) hi++;
    end
    check("pulse_width", 16'(hi), 16'd1);
    check("pulse_cnt", press_cnt, 16'd2);

    // Toggle: invert on press only.
    for (int i = 0; i < 10; i++) step(4'b0100);
    check("toggle_p1", 16'(btn_out[2]), 16'h1);
    for (int i = 0; i < 10; i++) step(4'b0000);
    check("toggle_rel", 16'(btn_out[2]), 16'h1);
    for (int i = 0; i < 10; i++) step(4'b0100);
    check("toggle_p2", 16'(btn_out[2]), 16'h0);
    for (int i = 0; i < 10; i++) step(4'b0000);
    check("toggle_cnt", press_cnt, 16'd4);

    // Stretch: second press lands exactly at expiry and reloads (8 gap + 8 stretch).
    hi = 0; rises = 0; prev3 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step((i < 4 || (i >= 8 && i < 12)) ? 4'b1000 : 4'b0000);
      if (btn_out[3]) hi++;
      if (btn_out[3] && !prev3) rises++;
      prev3 = btn_out[3];
    end
    check("stretch_high", 16'(hi), 16'd16);
    check("stretch_rises", 16'(rises), 16'd1);
    check("stretch_cnt", press_cnt, 16'd6);

    // All four lanes in pulse mode pressed together.
    cur_mode = 8'h55;
    step(4'b0000); step(4'b0000);
    quad = 0; maxd = 0; prev_cnt = press_cnt;
    for (int i = 0; i < 12; i++) begin
      step(i < 6 ? 4'hF : 4'h0);
      if (btn_out == 4'hF) quad++;
      if (int'(press_cnt - prev_cnt) > maxd) maxd = int'(press_cnt - prev_cnt);
      prev_cnt = press_cnt;
    end
    check("quad_pulses", 16'(quad), 16'd1);
    check("quad_delta", 16'(maxd), 16'd4);
    check("quad_cnt", press_cnt, 16'd10);

    // Stretch interrupted by a mode change to level while held.
    cur_mode = 8'hE4;
    step(4'b0000); step(4'b0000);
    n = 0;
    do begin
      step(4'b1000);
      n++;
    end while (!btn_out[3] && n < 20);
    check("mc_press_seen", 16'(btn_out[3]), 16'h1);
    for (int i = 0; i < 3; i++) step(4'b1000);
    cur_mode = 8'h24;
    step(4'b1000);
    check("mc_clear", 16'(btn_out[3]), 16'h0);
    step(4'b1000);
    check("mc_follow", 16'(btn_out[3]), 16'h1);
    check("mc_db", 16'(btn_db[3]), 16'h1);
    check("mc_cnt", press_cnt, 16'd11);

    // Asynchronous reset in the middle of a stretch, button held through release.
    cur_mode = 8'hE4;
    for (int i = 0; i < 6; i++) step(4'b0000);
    n = 0;
    do begin
      step(4'b1000);
      n++;
    end while (!btn_out[3] && n < 20);
    step(4'b1000); step(4'b1000);
    #2 rst = 1'b1;
    #1;
    check_zero("rst_mid");
    model_reset();
    @(negedge sysclk);
    rst = 1'b0;
    n = 0;
    do begin
      step(4'b1000);
      n++;
    end while (!btn_db[3] && n < 20);
    check("rel_latency", 16'(n), 16'(DB + 2));
    check("rel_cnt", press_cnt, 16'd1);

    // Randomized stimulus against the model.
    rr = 4'b1000;
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 7) == 0) rr[i] = !rr[i];
      end
      if ($urandom_range(0, 39) == 0) cur_mode = 8'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        #1;
        check_zero("rst_rand");
        model_reset();
        @(negedge sysclk);
        rst = 1'b0;
      end
      step(rr);
    end

    // 16-bit wrap: 16383 then 16384 quad presses.
    @(negedge sysclk);
    for (int i = 0; i < 16383; i++) begin
      w_raw = 4'hF; @(negedge sysclk);
      w_raw = 4'h0; @(negedge sysclk);
    end
    repeat (3) @(negedge sysclk);
    check("wrap_near", w_cnt, 16'hFFFC);
    w_raw = 4'hF; @(negedge sysclk);
    w_raw = 4'h0; @(negedge sysclk);
    repeat (3) @(negedge sysclk);
    check("wrap_zero", w_cnt, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
